// File: rtl/simple_pkg.sv
// Shared definitions for the SIMPLE pipelined core: widths, the bubble
// instruction encoding and the fetch-stage state type.
package simple_pkg;

    localparam int PC_W   = 16;
    localparam int INST_W = 16;

    // class 11, opcode 1110: no RegWrite, no MemWrite, no Halt, Branch=111
    localparam logic [15:0] BUBBLE = 16'hC0E0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/fetch_if_id_if.sv
// Fetch-stage bundle: hazard/branch controls in, instruction-memory bus and
// IF/ID slot out. The master side is the fetch stage itself.
interface fetch_if_id_if
    import simple_pkg::*;
#(
    parameter int PC_W   = simple_pkg::PC_W,
    parameter int INST_W = simple_pkg::INST_W
);

    logic              stall;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              halt_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_en;
    logic [INST_W-1:0] imem_rdata;
    logic [INST_W-1:0] id_inst;
    logic [PC_W-1:0]   id_pc1;
    logic              id_valid;
    logic              halted;

    modport master (
        input  stall, redirect, redirect_pc, halt_req, imem_rdata,
        output imem_addr, imem_en, id_inst, id_pc1, id_valid, halted
    );

    modport slave (
        output stall, redirect, redirect_pc, halt_req, imem_rdata,
        input  imem_addr, imem_en, id_inst, id_pc1, id_valid, halted
    );

endinterface

// File: rtl/fetch_if_id_pc_reg.sv
// PC register: selects the fetch address (redirect target or current PC)
// and loads fetch address + 1 whenever a fetch is issued.
module pc_reg
    import simple_pkg::*;
#(
    parameter int              PC_W     = simple_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic            advance,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] fetch_addr
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        fetch_addr = redirect ? redirect_pc : pc_q;
        pc_d       = pc_q;
        if (rst) begin
            pc_d = RESET_PC;
        end else if (advance) begin
            // modulo 2^PC_W by width truncation
            pc_d = fetch_addr + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_if_id.sv
// Instruction-fetch stage and IF/ID register: drives the synchronous imem,
// tracks the in-flight fetch and presents instructions to decode.
module fetch_if_id
    import simple_pkg::*;
#(
    parameter int              PC_W     = simple_pkg::PC_W,
    parameter int              INST_W   = simple_pkg::INST_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_if_id_if.master bus
);

    localparam logic [INST_W-1:0] BUBBLE_W = INST_W'(BUBBLE);

    state_e            state_q, state_d;
    logic              pend_valid_q, pend_valid_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic [PC_W-1:0]   id_pc1_q, id_pc1_d;
    logic              id_valid_q, id_valid_d;

    logic            running;
    logic            take_redirect;
    logic            do_halt;
    logic            do_normal;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] fetch_addr;

    // Priority: rst > redirect > stall > halt_req > normal; HALTED ignores all but rst.
    assign running       = !rst && (state_q == RUN);
    assign take_redirect = running && bus.redirect;
    assign do_halt       = running && !bus.redirect && !bus.stall && bus.halt_req;
    assign do_normal     = running && !bus.redirect && !bus.stall && !bus.halt_req;

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .redirect    (take_redirect),
        .advance     (take_redirect || do_normal),
        .redirect_pc (bus.redirect_pc),
        .pc          (pc),
        .fetch_addr  (fetch_addr)
    );

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        id_inst_d    = id_inst_q;
        id_pc1_d     = id_pc1_q;
        id_valid_d   = id_valid_q;

        if (rst) begin
            state_d      = RUN;
            pend_valid_d = 1'b0;
            pend_pc_d    = '0;
            id_inst_d    = BUBBLE_W;
            id_pc1_d     = '0;
            id_valid_d   = 1'b0;
        end else if (take_redirect) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = bus.redirect_pc;
            id_inst_d    = BUBBLE_W;
            id_valid_d   = 1'b0;
        end else if (do_halt) begin
            state_d      = HALTED;
            pend_valid_d = 1'b0;
            id_inst_d    = BUBBLE_W;
            id_valid_d   = 1'b0;
        end else if (do_normal) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = pc;
            id_inst_d    = pend_valid_q ? bus.imem_rdata : BUBBLE_W;
            id_pc1_d     = pend_pc_q + PC_W'(1);
            id_valid_d   = pend_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        state_q      <= state_d;
        pend_valid_q <= pend_valid_d;
        pend_pc_q    <= pend_pc_d;
        id_inst_q    <= id_inst_d;
        id_pc1_q     <= id_pc1_d;
        id_valid_q   <= id_valid_d;
    end

    assign bus.imem_addr = fetch_addr;
    assign bus.imem_en   = take_redirect || do_normal;
    assign bus.id_inst   = id_inst_q;
    assign bus.id_pc1    = id_pc1_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.halted    = (state_q == HALTED);

endmodule
